// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and enums for the ball controller.
// Visible raster size, Avalon register map, sequencer states.
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int VACTIVE = 480;

  typedef enum logic [2:0] {
    A_X_LO = 3'd0,
    A_X_HI = 3'd1,
    A_Y_LO = 3'd2,
    A_Y_HI = 3'd3,
    A_RAD  = 3'd4,
    A_VEL  = 3'd5,
    A_CTRL = 3'd6,
    A_STAT = 3'd7
  } reg_addr_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_MOVE,
    S_DONE
  } state_e;

endpackage

// File: rtl/vga_ball_axis_step.sv
// vga_ball_axis_step: one axis of per-frame ball motion with wall bounce.
// In: pos, vel (4b signed), r, lim. Out: pos_nxt, vel_nxt, bounce.
module vga_ball_axis_step (
  input  logic [9:0]  pos,
  input  logic [3:0]  vel,
  input  logic [6:0]  r,
  input  logic [10:0] lim,
  output logic [9:0]  pos_nxt,
  output logic [3:0]  vel_nxt,
  output logic        bounce
);

  logic signed [11:0] n;
  logic signed [11:0] lo;
  logic signed [11:0] hi;
  logic signed [4:0]  neg;
  logic [3:0]         vneg;

  assign n  = $signed({2'b00, pos})
            + $signed({{8{vel[3]}}, vel});
  assign lo = $signed({5'b0, r});
  assign hi = $signed({1'b0, lim})
            - 12'sd1 - lo;

  // -(-8) is +8, which does not fit in 4 bits
  assign neg  = -$signed({vel[3], vel});
  assign vneg = (neg == 5'sd8) ? 4'd7
                               : neg[3:0];

  always_comb begin
    pos_nxt = n[9:0];
    vel_nxt = vel;
    bounce  = 1'b0;
    if (n < lo) begin
      pos_nxt = {3'b0, r};
      vel_nxt = vneg;
      bounce  = 1'b1;
    end else if (n > hi) begin
      pos_nxt = hi[9:0];
      vel_nxt = vneg;
      bounce  = 1'b1;
    end
  end

endmodule

// File: rtl/vga_ball_ctrl.sv
// vga_ball_ctrl: Avalon ball registers, double-buffered, committed at vblank.
// Ports: Avalon slave (chipselect/write/read/address/writedata/readdata),
// hcount/vcount from vga_counters, live ball_x/ball_y/ball_r, sticky irq.
module vga_ball_ctrl
  import vga_pkg::*;
#(
  parameter int HACTIVE_P = HACTIVE,
  parameter int VACTIVE_P = VACTIVE,
  parameter int RST_X     = 320,
  parameter int RST_Y     = 240,
  parameter int RST_R     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [6:0]  ball_r,
  output logic        irq
);

  logic [9:0] sx, sy;
  logic [6:0] sr;
  logic [7:0] svel;
  logic [7:0] vel;
  logic       irq_en, auto_en, pending;
  state_e     state;

  logic       fs, wr_en, rd_en, set_pend;
  reg_addr_e  addr;
  logic [7:0] rdata;

  logic [9:0] x_nxt, y_nxt;
  logic [3:0] dx_nxt, dy_nxt;
  logic       x_b, y_b;

  assign addr  = reg_addr_e'(address);
  assign fs    = (vcount == 10'(VACTIVE_P))
              && (hcount == 11'd0);
  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;

  assign set_pend = wr_en
    && ((address <= 3'd4)
     || (addr == A_CTRL && writedata[0]));

  vga_ball_axis_step u_x (
    .pos     (ball_x),
    .vel     (vel[7:4]),
    .r       (ball_r),
    .lim     (11'(HACTIVE_P)),
    .pos_nxt (x_nxt),
    .vel_nxt (dx_nxt),
    .bounce  (x_b)
  );

  vga_ball_axis_step u_y (
    .pos     (ball_y),
    .vel     (vel[3:0]),
    .r       (ball_r),
    .lim     (11'(VACTIVE_P)),
    .pos_nxt (y_nxt),
    .vel_nxt (dy_nxt),
    .bounce  (y_b)
  );

  always_comb begin
    rdata = 8'h00;
    unique case (addr)
      A_X_LO: rdata = sx[7:0];
      A_X_HI: rdata = {6'b0, sx[9:8]};
      A_Y_LO: rdata = sy[7:0];
      A_Y_HI: rdata = {6'b0, sy[9:8]};
      A_RAD:  rdata = {1'b0, sr};
      A_VEL:  rdata = svel;
      A_CTRL: rdata = {5'b0, irq_en, auto_en, 1'b0};
      A_STAT: rdata = {6'b0, irq, pending};
    endcase
  end

  // Statement order matters: hardware updates (bounce
  // write-back, irq set, pending set) follow CPU writes
  // so that they win on the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sx       <= 10'(RST_X);
      sy       <= 10'(RST_Y);
      sr       <= 7'(RST_R);
      svel     <= 8'h00;
      ball_x   <= 10'(RST_X);
      ball_y   <= 10'(RST_Y);
      ball_r   <= 7'(RST_R);
      vel      <= 8'h00;
      irq_en   <= 1'b0;
      auto_en  <= 1'b0;
      pending  <= 1'b0;
      irq      <= 1'b0;
      readdata <= 8'h00;
    end else begin
      if (rd_en) readdata <= rdata;

      if (wr_en) begin
        unique case (addr)
          A_X_LO: sx[7:0] <= writedata;
          A_X_HI: sx[9:8] <= writedata[1:0];
          A_Y_LO: sy[7:0] <= writedata;
          A_Y_HI: sy[9:8] <= writedata[1:0];
          A_RAD:  sr      <= writedata[6:0];
          A_VEL:  svel    <= writedata;
          A_CTRL: {irq_en, auto_en} <= writedata[2:1];
          A_STAT: if (writedata[1]) irq <= 1'b0;
        endcase
      end

      unique case (state)
        S_IDLE: begin
          if (fs) state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (pending) begin
            ball_x  <= sx;
            ball_y  <= sy;
            ball_r  <= sr;
            vel     <= svel;
            pending <= 1'b0;
          end
          state <= S_MOVE;
        end
        S_MOVE: begin
          if (auto_en) begin
            ball_x <= x_nxt;
            ball_y <= y_nxt;
            vel    <= {dx_nxt, dy_nxt};
            if (x_b) svel[7:4] <= dx_nxt;
            if (y_b) svel[3:0] <= dy_nxt;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (irq_en) irq <= 1'b1;
          state <= S_IDLE;
        end
      endcase

      if (set_pend) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_ball_ctrl.sv
// tb_vga_ball_ctrl: directed + random checks of vga_ball_ctrl
// against an arithmetic model of the register/commit/bounce rules.
module tb_vga_ball_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic [10:0] hcount = 11'd100;
  logic [9:0]  vcount = 10'd200;
  logic [9:0]  ball_x, ball_y;
  logic [6:0]  ball_r;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_sx, m_sy, m_sr, m_sdx, m_sdy;
  int m_lx, m_ly, m_lr, m_ldx, m_ldy;
  int m_irq_en, m_auto, m_pend, m_irq;

  logic [7:0] rv;

  vga_ball_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_r     (ball_r),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int s4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int neg_sat(input int v);
    return (-v > 7) ? 7 : -v;
  endfunction

  function automatic int vel_byte();
    return ((m_sdx & 15) << 4) | (m_sdy & 15);
  endfunction

  task automatic model_reset();
    m_sx = 320; m_sy = 240; m_sr = 16;
    m_sdx = 0; m_sdy = 0;
    m_lx = 320; m_ly = 240; m_lr = 16;
    m_ldx = 0; m_ldy = 0;
    m_irq_en = 0; m_auto = 0;
    m_pend = 0; m_irq = 0;
  endtask

  task automatic model_write(input int a, input int d);
    case (a)
      0: begin m_sx = (m_sx & 'h300) | d; m_pend = 1; end
      1: begin m_sx = (m_sx & 'hff) | ((d & 3) << 8); m_pend = 1; end
      2: begin m_sy = (m_sy & 'h300) | d; m_pend = 1; end
      3: begin m_sy = (m_sy & 'hff) | ((d & 3) << 8); m_pend = 1; end
      4: begin m_sr = d & 127; m_pend = 1; end
      5: begin m_sdx = s4(d >> 4); m_sdy = s4(d & 15); end
      6: begin
        m_irq_en = (d >> 2) & 1;
        m_auto = (d >> 1) & 1;
        if (d & 1) m_pend = 1;
      end
      default: if (d & 2) m_irq = 0;
    endcase
  endtask

  task automatic axis(inout int p, inout int v,
                      input int r, input int lim,
                      output bit b);
    int n;
    n = p + v;
    b = 1'b1;
    if (n < r) begin
      p = r; v = neg_sat(v);
    end else if (n > lim - 1 - r) begin
      p = lim - 1 - r; v = neg_sat(v);
    end else begin
      p = n; b = 1'b0;
    end
  endtask

  task automatic model_frame();
    bit bx, by;
    if (m_pend != 0) begin
      m_lx = m_sx; m_ly = m_sy; m_lr = m_sr;
      m_ldx = m_sdx; m_ldy = m_sdy;
      m_pend = 0;
    end
    if (m_auto != 0) begin
      axis(m_lx, m_ldx, m_lr, 640, bx);
      axis(m_ly, m_ldy, m_lr, 480, by);
      if (bx) m_sdx = m_ldx;
      if (by) m_sdy = m_ldy;
    end
    if (m_irq_en != 0) m_irq = 1;
  endtask

  task automatic wr(input int a, input int d);
    chipselect = 1'b1; write = 1'b1;
    address = 3'(a); writedata = 8'(d);
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic mwr(input int a, input int d);
    wr(a, d);
    model_write(a, d & 255);
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1;
    address = 3'(a);
    step();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic fs_on();
    vcount = 10'd480; hcount = 11'd0;
  endtask

  task automatic fs_off();
    vcount = 10'd200; hcount = 11'd100;
  endtask

  task automatic fire();
    fs_on(); step(); fs_off();
    step(); step(); step();
    model_frame();
  endtask

  task automatic check_all(input string tag);
    logic [7:0] d;
    chk({tag, "_x"}, ball_x, m_lx);
    chk({tag, "_y"}, ball_y, m_ly);
    chk({tag, "_r"}, ball_r, m_lr);
    chk({tag, "_irq"}, irq, m_irq);
    rd(5, d);
    chk({tag, "_vel"}, d, vel_byte());
    rd(7, d);
    chk({tag, "_stat"}, d, (m_irq << 1) | m_pend);
  endtask

  initial begin
    model_reset();
    step(); step();
    chk("rst_x", ball_x, 320);
    chk("rst_y", ball_y, 240);
    chk("rst_r", ball_r, 16);
    chk("rst_irq", irq, 0);
    chk("rst_rd", readdata, 0);
    reset = 1'b0;
    step();

    // staged write is invisible until the frame strobe
    mwr(0, 100); mwr(1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("x_hold", ball_x, 320);
    end
    rd(7, rv); chk("pend_set", rv, 1);
    fs_on(); step(); fs_off();
    chk("x_at_fs", ball_x, 320);
    step();
    chk("x_commit", ball_x, 100);
    step(); step();
    model_frame();
    rd(7, rv); chk("pend_clr", rv, 0);

    // right-wall bounce on x
    mwr(0, 118); mwr(1, 2); mwr(4, 8);
    mwr(5, 'h30); mwr(6, 'h02);
    fire();
    chk("xb_pos", ball_x, 631);
    rd(5, rv); chk("xb_vel", rv, 'hD0);
    check_all("xb");

    // top-wall bounce on y, then free motion
    mwr(2, 10); mwr(3, 0); mwr(4, 10);
    mwr(5, 'h0E);
    fire();
    chk("yb_pos", ball_y, 10);
    rd(5, rv); chk("yb_vel", rv, 'h02);
    check_all("yb");
    fire();
    chk("ym_pos", ball_y, 12);
    check_all("ym");

    // irq timing and clear
    mwr(6, 'h04);
    fs_on(); step(); fs_off();
    chk("irq_e0", irq, 0);
    step(); chk("irq_e1", irq, 0);
    step(); chk("irq_e2", irq, 0);
    step(); chk("irq_e3", irq, 1);
    model_frame();
    rd(7, rv); chk("irq_stat", rv, 2);
    mwr(7, 2);
    chk("irq_clr", irq, 0);
    fs_on(); step(); fs_off();
    step(); step();
    chipselect = 1'b1; write = 1'b1;
    address = 3'd7; writedata = 8'h02;
    step();
    chipselect = 1'b0; write = 1'b0;
    model_frame();
    chk("irq_set_wins", irq, 1);
    mwr(7, 2); mwr(6, 0);
    chk("irq_clr2", irq, 0);

    // CPU write on the COMMIT cycle
    mwr(0, 50); mwr(1, 0);
    fire();
    chk("cw_base", ball_x, 50);
    mwr(0, 60);
    fs_on(); step(); fs_off();
    chipselect = 1'b1; write = 1'b1;
    address = 3'd0; writedata = 8'd77;
    step();
    chipselect = 1'b0; write = 1'b0;
    step(); step();
    model_frame();
    model_write(0, 77);
    chk("cw_old", ball_x, 60);
    rd(7, rv); chk("cw_pend", rv, 1);
    fire();
    chk("cw_new", ball_x, 77);

    // randomized register traffic and frames
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++)
        mwr($urandom_range(0, 7), $urandom_range(0, 255));
      fire();
      check_all($sformatf("rnd%0d", it));
    end

    // reset in the middle of MOVE
    mwr(6, 'h06); mwr(0, 'h55); mwr(1, 0); mwr(4, 5);
    fire();
    rd(0, rv); chk("pre_rst_rd", rv, 'h55);
    chk("pre_rst_irq", irq, 1);
    fs_on(); step(); fs_off();
    step();
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("mr_x", ball_x, 320);
    chk("mr_y", ball_y, 240);
    chk("mr_r", ball_r, 16);
    chk("mr_irq", irq, 0);
    chk("mr_rd", readdata, 0);
    reset = 1'b0;
    step();
    rd(0, rv); chk("mr_sx", rv, 64);
    rd(6, rv); chk("mr_ctrl", rv, 0);
    fire();
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
